// File: rtl/fsm5_if.sv
// fsm5_if: serial-detector connection bundle.
//   seq  - serial data bit driven toward the detector
//   dout - one-cycle detect flag returned by the detector
// Modports: master drives seq and observes dout; slave is the detector side.
interface fsm5_if;
    logic seq;
    logic dout;

    modport master (output seq, input dout);
    modport slave  (input seq, output dout);
endinterface

// File: rtl/fsm5.sv
// fsm5: Moore detector for the serial pattern 1-0-1-1 (first bit first).
// Ports:
//   clk  - system clock, all updates on the rising edge
//   rst  - synchronous active-high reset, returns to S0 and clears dout
//   bus  - fsm5_if slave: seq (serial bit in), dout (high while in DETECT)
// OVERLAP=1 lets the tail of a match seed the next one; OVERLAP=0 restarts
// after each match.
module fsm5 #(
    parameter bit OVERLAP = 1'b1
) (
    input  logic   clk,
    input  logic   rst,
    fsm5_if.slave  bus
);

    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        S0 = 3'b000,
        S1 = 3'b001,
        S2 = 3'b010,
        S3 = 3'b011,
        S4 = 3'b100
    } state_t;

    state_t state;
    state_t state_next;
    logic   dout_q;

    // State register; dout is registered alongside it, decoded from the
    // next state so it is high exactly while state == S4.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S0;
            dout_q <= 1'b0;
        end else begin
            state  <= state_next;
            dout_q <= (state_next == S4);
        end
    end

    // Next-state logic
    always_comb begin
        state_next = S0;
        case (state)
            S0: state_next = bus.seq ? S1 : S0;
            S1: state_next = bus.seq ? S1 : S2;
            S2: state_next = bus.seq ? S3 : S0;
            S3: state_next = bus.seq ? S4 : S2;
            // After a match the trailing "1" can be reused as the head of
            // "10" only in overlapping mode.
            S4: begin
                if (bus.seq)
                    state_next = S1;
                else
                    state_next = OVERLAP ? S2 : S0;
            end
            // Unused encodings recover to S0.
            default: state_next = S0;
        endcase
    end

    assign bus.dout = dout_q;

endmodule

// File: tb/tb_fsm5.sv
// tb_fsm5: directed check of fsm5 in both overlap modes side by side.
module tb_fsm5;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    fsm5_if bus_ov ();
    fsm5_if bus_no ();

    fsm5 #(.OVERLAP(1'b1)) dut_ov (.clk(clk), .rst(rst), .bus(bus_ov.slave));
    fsm5 #(.OVERLAP(1'b0)) dut_no (.clk(clk), .rst(rst), .bus(bus_no.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts and reports mismatches.
    task automatic check(input string tag, input logic got, input logic exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%b exp=%b", tag, got, exp);
        end
    endtask

    // Drive one bit away from the edge, then sample just after the edge.
    task automatic step(input logic s, input logic r);
        @(negedge clk);
        bus_ov.seq = s;
        bus_no.seq = s;
        rst        = r;
        @(posedge clk);
        #1;
    endtask

    // Apply n bits (MSB first) and check both detectors after every edge.
    task automatic run_seq(input string tag, input int n, input logic [15:0] s,
                           input logic [15:0] eo, input logic [15:0] en);
        for (int i = n - 1; i >= 0; i--) begin
            step(s[i], 1'b0);
            check($sformatf("%s ov e%0d", tag, n - i), bus_ov.dout, eo[i]);
            check($sformatf("%s no e%0d", tag, n - i), bus_no.dout, en[i]);
        end
    endtask

    task automatic do_reset(input string tag);
        step(1'b1, 1'b1);
        check({tag, " rst1 ov"}, bus_ov.dout, 1'b0);
        check({tag, " rst1 no"}, bus_no.dout, 1'b0);
        step(1'b0, 1'b1);
        check({tag, " rst2 ov"}, bus_ov.dout, 1'b0);
        check({tag, " rst2 no"}, bus_no.dout, 1'b0);
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        rst        = 1'b1;
        bus_ov.seq = 1'b0;
        bus_no.seq = 1'b0;

        // Reset with seq toggling, then idle zeros
        do_reset("reset");
        run_seq("idle", 3, 16'b000, 16'b000, 16'b000);

        // Basic match followed by a 0
        do_reset("basic");
        run_seq("basic", 5, 16'b10110, 16'b00010, 16'b00010);

        // 1011011 then 011: overlap fires at 4,7,10; non-overlap at 4,10
        do_reset("ovl");
        run_seq("ovl", 10, 16'b1011011011, 16'b0001001001, 16'b0001000001);

        // Near misses: S1 self-loop and S3->S2 on 0
        do_reset("near");
        run_seq("near", 7, 16'b1101011, 16'b0000001, 16'b0000001);

        // Reset mid-pattern discards the 101 prefix
        do_reset("mid");
        run_seq("mid pre", 3, 16'b101, 16'b000, 16'b000);
        step(1'b1, 1'b1);
        check("mid rst ov", bus_ov.dout, 1'b0);
        check("mid rst no", bus_no.dout, 1'b0);
        run_seq("mid post", 1, 16'b1, 16'b0, 16'b0);
        run_seq("mid fresh", 4, 16'b1011, 16'b0001, 16'b0001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
